// File: rtl/mem_arbiter_n.sv
// mem_arbiter_n: funnels NUM_PORTS level-held read/write requesters onto one registered memory port.
// Latency: mem strobe the cycle after a request is seen in IDLE; up_resp the cycle after mem_resp (3 min).
// Backpressure: one transaction in flight; losers keep their request level until their own up_resp.
// Build option ARB_ROUND_ROBIN_EN selects round-robin grant; otherwise lowest-numbered port wins.
module mem_arbiter_n #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            up_read,
    input  logic [NUM_PORTS-1:0]            up_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] up_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] up_wdata,
    output logic [NUM_PORTS-1:0]            up_resp,
    output logic [DATA_WIDTH-1:0]           up_rdata,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_resp,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);
    localparam int IDX_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_next;
    logic [NUM_PORTS-1:0]  pending;
    logic                  any_pending;
    logic [IDX_W-1:0]      grant_idx;
    logic [IDX_W-1:0]      winner;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;

    assign pending     = up_read | up_write;
    assign any_pending = |pending;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    // Scan from the pointer upward with wrap; descending loop so the nearest pending port wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (pending[IDX_W'(idx)]) grant_idx = IDX_W'(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == IDLE && any_pending) begin
            rr_ptr <= (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end
`else
    always_comb begin
        grant_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (pending[IDX_W'(k)]) grant_idx = IDX_W'(k);
        end
    end
`endif

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant_idx == IDX_W'(k)) begin
                addr_sel  = up_address[k*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_sel = up_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_pending) state_next = BUSY;
            BUSY:    if (mem_resp) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Everything downstream is latched at grant, so requester activity during BUSY/RESP is invisible.
    always_ff @(posedge clk) begin
        if (reset) begin
            winner      <= '0;
            up_resp     <= '0;
            up_rdata    <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            up_resp <= '0;
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        winner      <= grant_idx;
                        mem_address <= addr_sel;
                        mem_wdata   <= wdata_sel;
                        mem_write   <= up_write[grant_idx];
                        mem_read    <= ~up_write[grant_idx];
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        up_rdata  <= mem_rdata;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        up_resp   <= {{(NUM_PORTS-1){1'b0}}, 1'b1} << winner;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: a 2-port and a 4-port instance checked against a grant-order model.
module tb_mem_arbiter_n;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]   r2, w2, resp2;
    logic [31:0]  a2;
    logic [255:0] d2;
    logic [127:0] rdata2, mwd2, mrd2;
    logic         mr2, mw2, mresp2;
    logic [15:0]  ma2;

    logic [3:0]   r4, w4, resp4;
    logic [63:0]  a4;
    logic [511:0] d4;
    logic [127:0] rdata4, mwd4, mrd4;
    logic         mr4, mw4, mresp4;
    logic [15:0]  ma4;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr2  = 0;
    int ptr4  = 0;

    logic [15:0]  ea [2];
    logic [127:0] ed [2];
    bit           ew [2];

    mem_arbiter_n #(.NUM_PORTS(2), .ADDR_WIDTH(16), .DATA_WIDTH(128)) dut2 (
        .clk(clk), .reset(reset), .up_read(r2), .up_write(w2), .up_address(a2),
        .up_wdata(d2), .up_resp(resp2), .up_rdata(rdata2), .mem_read(mr2),
        .mem_write(mw2), .mem_address(ma2), .mem_wdata(mwd2), .mem_resp(mresp2),
        .mem_rdata(mrd2));

    mem_arbiter_n #(.NUM_PORTS(4), .ADDR_WIDTH(16), .DATA_WIDTH(128)) dut4 (
        .clk(clk), .reset(reset), .up_read(r4), .up_write(w4), .up_address(a4),
        .up_wdata(d4), .up_resp(resp4), .up_rdata(rdata4), .mem_read(mr4),
        .mem_write(mw4), .mem_address(ma4), .mem_wdata(mwd4), .mem_resp(mresp4),
        .mem_rdata(mrd4));

    // Grant rule: first pending port scanning from ptr (round-robin) or from 0 (fixed).
    function automatic int pick(input logic [7:0] pend, input int n, input int ptr);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = RR ? (ptr + k) % n : k;
            if (pend[3'(idx)]) return idx;
        end
        return -1;
    endfunction

    task automatic req2(input int p, input bit rd, input bit wr,
                        input logic [15:0] addr, input logic [127:0] dat);
        r2[p] = rd;
        w2[p] = wr;
        a2[p*16 +: 16]   = addr;
        d2[p*128 +: 128] = dat;
        ea[p] = addr;
        ed[p] = dat;
        ew[p] = wr;
    endtask

    task automatic drop2(input int p);
        r2[p] = 1'b0;
        w2[p] = 1'b0;
    endtask

    task automatic wait_strobe2(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mr2 || mw2) begin cyc = i; break; end
        end
    endtask

    task automatic wait_strobe4(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mr4 || mw4) begin cyc = i; break; end
        end
    endtask

    task automatic test_reset;
        int busy_cycles;
        reset = 1'b1;
        r2 = '0; w2 = '0; a2 = '0; d2 = '0; mresp2 = 1'b0; mrd2 = '0;
        r4 = '0; w4 = '0; a4 = '0; d4 = '0; mresp4 = 1'b0; mrd4 = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({mr2, mw2, resp2, ma2, mwd2, rdata2} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs2: got %h required 0", {mr2, mw2, resp2, ma2, mwd2, rdata2});
        end
        n_cmp++;
        if ({mr4, mw4, resp4, ma4, mwd4, rdata4} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs4: got %h required 0", {mr4, mw4, resp4, ma4, mwd4, rdata4});
        end
        reset = 1'b0;
        ptr2 = 0;
        ptr4 = 0;
        busy_cycles = 0;
        repeat (10) begin
            @(negedge clk);
            if ({mr2, mw2, resp2, ma2, mwd2, rdata2, mr4, mw4, resp4} !== '0) busy_cycles++;
        end
        n_cmp++;
        if (busy_cycles !== 0) begin
            n_bad++;
            $display("FAIL idle_quiet: got %0d active cycles required 0", busy_cycles);
        end
    endtask

    task automatic test_single_read;
        int cyc;
        logic [127:0] rd;
        rd = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        req2(1, 1'b1, 1'b0, 16'h1A2B, '0);
        wait_strobe2(cyc);
        n_cmp++;
        if (cyc !== 1 || mr2 !== 1'b1 || mw2 !== 1'b0 || ma2 !== 16'h1A2B) begin
            n_bad++;
            $display("FAIL single_issue: got cyc=%0d rd=%b wr=%b addr=%h required cyc=1 rd=1 wr=0 addr=1a2b",
                     cyc, mr2, mw2, ma2);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (mr2 !== 1'b1 || ma2 !== 16'h1A2B) begin
            n_bad++;
            $display("FAIL single_hold: got rd=%b addr=%h required rd=1 addr=1a2b", mr2, ma2);
        end
        mrd2 = rd;
        mresp2 = 1'b1;
        @(negedge clk);
        mresp2 = 1'b0;
        drop2(1);
        n_cmp++;
        if (resp2 !== 2'b10 || mr2 !== 1'b0 || mw2 !== 1'b0) begin
            n_bad++;
            $display("FAIL single_resp: got resp=%b rd=%b wr=%b required resp=10 rd=0 wr=0", resp2, mr2, mw2);
        end
        n_cmp++;
        if (rdata2 !== rd) begin
            n_bad++;
            $display("FAIL single_rdata: got %h required %h", rdata2, rd);
        end
        @(negedge clk);
        n_cmp++;
        if (resp2 !== 2'b00) begin
            n_bad++;
            $display("FAIL single_pulse: got resp=%b required 00", resp2);
        end
        ptr2 = 0;
    endtask

    task automatic test_rw_both;
        int cyc;
        req2(0, 1'b1, 1'b1, 16'h0BEE, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C);
        wait_strobe2(cyc);
        n_cmp++;
        if (cyc !== 1 || mw2 !== 1'b1 || mr2 !== 1'b0) begin
            n_bad++;
            $display("FAIL rw_both_op: got cyc=%0d rd=%b wr=%b required cyc=1 rd=0 wr=1", cyc, mr2, mw2);
        end
        n_cmp++;
        if (ma2 !== 16'h0BEE || mwd2 !== 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C) begin
            n_bad++;
            $display("FAIL rw_both_data: got addr=%h wdata=%h", ma2, mwd2);
        end
        mresp2 = 1'b1;
        @(negedge clk);
        mresp2 = 1'b0;
        drop2(0);
        n_cmp++;
        if (resp2 !== 2'b01) begin
            n_bad++;
            $display("FAIL rw_both_resp: got %b required 01", resp2);
        end
        @(negedge clk);
        ptr2 = 1;
    endtask

    task automatic test_simultaneous;
        int cyc, exp;
        logic [1:0] served;
        served = '0;
        req2(0, 1'b0, 1'b1, 16'h0100, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        req2(1, 1'b1, 1'b0, 16'h0200, '0);
        for (int n = 0; n < 2; n++) begin
            exp = pick({6'b0, r2 | w2}, 2, ptr2);
            wait_strobe2(cyc);
            n_cmp++;
            if (cyc !== 1 || ma2 !== ea[exp] || mw2 !== ew[exp] || mr2 !== !ew[exp]) begin
                n_bad++;
                $display("FAIL simul_grant%0d: got cyc=%0d addr=%h wr=%b required cyc=1 addr=%h wr=%b",
                         n, cyc, ma2, mw2, ea[exp], ew[exp]);
            end
            mresp2 = 1'b1;
            @(negedge clk);
            mresp2 = 1'b0;
            drop2(exp);
            served = served | resp2;
            n_cmp++;
            if (resp2 !== 2'(1 << exp)) begin
                n_bad++;
                $display("FAIL simul_resp%0d: got %b required %b", n, resp2, 2'(1 << exp));
            end
            ptr2 = (exp + 1) % 2;
            @(negedge clk);
        end
        n_cmp++;
        if (served !== 2'b11) begin
            n_bad++;
            $display("FAIL simul_no_loss: got served=%b required 11", served);
        end
    endtask

    task automatic test_random;
        int cyc, exp, lat;
        logic [127:0] rd;
        for (int t = 0; t < 40; t++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(r2[p] || w2[p]) && $urandom_range(0, 2) != 0) begin
                    int op;
                    op = $urandom_range(0, 2);
                    req2(p, op != 1, op != 0, 16'($urandom),
                         {$urandom, $urandom, $urandom, $urandom});
                end
            end
            if ((r2 | w2) == 2'b00) req2(t % 2, 1'b1, 1'b0, 16'($urandom), '0);
            exp = pick({6'b0, r2 | w2}, 2, ptr2);
            wait_strobe2(cyc);
            n_cmp++;
            if (cyc !== 1 || mw2 !== ew[exp] || mr2 !== !ew[exp] || ma2 !== ea[exp] ||
                (ew[exp] && mwd2 !== ed[exp])) begin
                n_bad++;
                $display("FAIL rand_issue%0d: got cyc=%0d rd=%b wr=%b addr=%h required cyc=1 port %0d wr=%b addr=%h",
                         t, cyc, mr2, mw2, ma2, exp, ew[exp], ea[exp]);
            end
            lat = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                drop2(exp);
                a2[exp*16 +: 16] = ~ea[exp];
            end
            repeat (lat) @(negedge clk);
            n_cmp++;
            if (mr2 !== !ew[exp] || mw2 !== ew[exp] || ma2 !== ea[exp]) begin
                n_bad++;
                $display("FAIL rand_hold%0d: got rd=%b wr=%b addr=%h required wr=%b addr=%h",
                         t, mr2, mw2, ma2, ew[exp], ea[exp]);
            end
            rd = {$urandom, $urandom, $urandom, $urandom};
            mrd2 = rd;
            mresp2 = 1'b1;
            @(negedge clk);
            mresp2 = 1'($urandom_range(0, 1));
            drop2(exp);
            n_cmp++;
            if (resp2 !== 2'(1 << exp) || rdata2 !== rd || mr2 !== 1'b0 || mw2 !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_resp%0d: got resp=%b rdata=%h required resp=%b rdata=%h",
                         t, resp2, rdata2, 2'(1 << exp), rd);
            end
            ptr2 = (exp + 1) % 2;
            @(negedge clk);
            mresp2 = 1'b0;
            n_cmp++;
            if (resp2 !== 2'b00 || mr2 !== 1'b0 || mw2 !== 1'b0) begin
                n_bad++;
                $display("FAIL rand_pulse%0d: got resp=%b rd=%b wr=%b required all 0", t, resp2, mr2, mw2);
            end
        end
        r2 = '0;
        w2 = '0;
    endtask

    task automatic test_starvation;
        int cyc, exp;
        for (int p = 0; p < 4; p++) a4[p*16 +: 16] = 16'h4000 + 16'(p);
        r4 = 4'hF;
        for (int n = 0; n < 5; n++) begin
            exp = pick(8'h0F, 4, ptr4);
            wait_strobe4(cyc);
            n_cmp++;
            if (cyc !== 1 || mr4 !== 1'b1 || ma4 !== 16'h4000 + 16'(exp)) begin
                n_bad++;
                $display("FAIL starve_issue%0d: got cyc=%0d rd=%b addr=%h required cyc=1 rd=1 addr=%h",
                         n, cyc, mr4, ma4, 16'h4000 + 16'(exp));
            end
            mresp4 = 1'b1;
            @(negedge clk);
            mresp4 = 1'b0;
            n_cmp++;
            if (resp4 !== 4'(1 << exp)) begin
                n_bad++;
                $display("FAIL starve_grant%0d: got resp=%b required %b", n, resp4, 4'(1 << exp));
            end
            ptr4 = (exp + 1) % 4;
            @(negedge clk);
        end
        r4 = '0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        int cyc, stray;
        req2(1, 1'b1, 1'b0, 16'h5555, '0);
        wait_strobe2(cyc);
        n_cmp++;
        if (cyc !== 1 || mr2 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_busy: got cyc=%0d rd=%b required cyc=1 rd=1", cyc, mr2);
        end
        reset = 1'b1;
        drop2(1);
        @(negedge clk);
        reset = 1'b0;
        ptr2 = 0;
        ptr4 = 0;
        n_cmp++;
        if (mr2 !== 1'b0 || mw2 !== 1'b0 || resp2 !== 2'b00) begin
            n_bad++;
            $display("FAIL mid_reset_abort: got rd=%b wr=%b resp=%b required all 0", mr2, mw2, resp2);
        end
        mrd2 = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
        mresp2 = 1'b1;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            mresp2 = 1'b0;
            if (resp2 !== 2'b00 || mr2 !== 1'b0 || mw2 !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_late_resp: got %0d active cycles required 0", stray);
        end
        n_cmp++;
        if (rdata2 !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_rdata: got %h required 0", rdata2);
        end
    endtask

    initial begin
        test_reset;
        test_single_read;
        test_rw_both;
        test_simultaneous;
        test_random;
        test_starvation;
        test_mid_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
